dsp_subtract_pipe: RTL and testbench

//   Pipelined signed subtractor, P = A - D, with valid/ready flow control.

---
 rtl/dsp_subtract_pipe_if.sv | 23 ++
 rtl/dsp_subtract_pipe.sv | 60 ++++++
 tb/tb_dsp_subtract_pipe.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_subtract_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// The slave modport is the subtractor side; the master modport is the producer/consumer side.
interface dsp_subtract_pipe_if #(
    parameter int WIDTH = 18
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;

    modport slave (
        input  in_valid, a, d, out_ready,
        output in_ready, out_valid, diff
    );

    modport master (
        output in_valid, a, d, out_ready,
        input  in_ready, out_valid, diff
    );
endinterface

// File: rtl/dsp_subtract_pipe.sv
// Pipelined signed subtractor diff = a - d with full-precision result and valid/ready flow control.
// All stages shift together on advance (global stall); res_count counts output handshakes and wraps.
module dsp_subtract_pipe #(
    parameter int WIDTH  = 18,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    dsp_subtract_pipe_if.slave     bus,
    output logic [CNT_W-1:0]       res_count
);

    logic [WIDTH:0]    data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic              advance;
    logic [WIDTH:0]    a_ext;
    logic [WIDTH:0]    d_ext;
    logic [WIDTH:0]    diff_in;

    // One extra bit of headroom makes every difference of two WIDTH-bit operands representable.
    assign a_ext   = {bus.a[WIDTH-1], bus.a};
    assign d_ext   = {bus.d[WIDTH-1], bus.d};
    assign diff_in = a_ext - d_ext;

    assign advance       = !valid_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.diff      = data_q[STAGES-1];

    // Data registers only load on valid entries so diff stays quiet across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= bus.in_valid;
            if (bus.in_valid) begin
                data_q[0] <= diff_in;
            end
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_count <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            res_count <= res_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dsp_subtract_pipe.sv
// Directed bench for dsp_subtract_pipe: reset, arithmetic extremes, stall hold, bubbles,
// mid-flight reset and counter wrap (second instance with a 4-bit counter).
module tb_dsp_subtract_pipe;
    localparam int WIDTH = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] res_count;
    logic [3:0]  res_count_w;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dsp_subtract_pipe_if #(.WIDTH(WIDTH)) bus ();
    dsp_subtract_pipe_if #(.WIDTH(WIDTH)) bus_w ();

    dsp_subtract_pipe #(.WIDTH(WIDTH), .STAGES(3), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .res_count (res_count)
    );

    dsp_subtract_pipe #(.WIDTH(WIDTH), .STAGES(3), .CNT_W(4)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_w),
        .res_count (res_count_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int av, input int dv);
        bus.in_valid = v;
        bus.a        = WIDTH'(av);
        bus.d        = WIDTH'(dv);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 0, 0);
        bus.out_ready   = 1'b0;
        bus_w.in_valid  = 1'b0;
        bus_w.a         = '0;
        bus_w.d         = '0;
        bus_w.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.diff !== '0) begin
            failures++; $display("FAIL reset_diff got=%0h want=0", bus.diff);
        end
        checks++;
        if (res_count !== 16'd0) begin
            failures++; $display("FAIL reset_res_count got=%0d want=0", res_count);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive(1'b1, 100, 30);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL basic_in_ready got=%b want=1", bus.in_ready);
        end
        tick();
        drive(1'b0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++;
            if (bus.out_valid !== (c == 3)) begin
                failures++; $display("FAIL basic_out_valid cycle=%0d got=%b want=%b", c, bus.out_valid, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if ($signed(bus.diff) !== 70) begin
                    failures++; $display("FAIL basic_diff got=%0d want=70", $signed(bus.diff));
                end
            end
            if (c == 4) begin
                checks++;
                if (res_count !== 16'd1) begin
                    failures++; $display("FAIL basic_res_count got=%0d want=1", res_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int av [3] = '{-131072, 131071, -5};
        int dv [3] = '{131071, -131072, -5};
        int ev [3] = '{-262143, 262143, 0};
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c < 3) drive(1'b1, av[c], dv[c]);
            else       drive(1'b0, 0, 0);
            #1;
            checks++;
            if (bus.out_valid !== (c >= 3 && c <= 5)) begin
                failures++; $display("FAIL b2b_out_valid cycle=%0d got=%b want=%b", c, bus.out_valid, (c >= 3 && c <= 5));
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if ($signed(bus.diff) !== ev[c-3]) begin
                    failures++; $display("FAIL b2b_diff idx=%0d got=%0d want=%0d", c - 3, $signed(bus.diff), ev[c-3]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          n = 0;
        int          k = 0;
        logic        orr;
        logic [WIDTH:0] held = '0;
        for (int c = 0; c <= 40; c++) begin
            orr = !(c >= 4 && c <= 8);
            bus.out_ready = orr;
            if (n < 10) drive(1'b1, n, 2 * n);
            else        drive(1'b0, 0, 0);
            #1;
            if (c == 4) held = bus.diff;
            if (bus.out_valid && !orr) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    failures++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", c, bus.in_ready);
                end
                if (c > 4) begin
                    checks++;
                    if (bus.diff !== held) begin
                        failures++; $display("FAIL bp_hold cycle=%0d got=%0d want=%0d", c, $signed(bus.diff), $signed(held));
                    end
                end
            end
            if (bus.out_valid && orr) begin
                checks++;
                if ($signed(bus.diff) !== -k) begin
                    failures++; $display("FAIL bp_diff idx=%0d got=%0d want=%0d", k, $signed(bus.diff), -k);
                end
                k++;
            end
            if (bus.in_valid && bus.in_ready) n++;
            tick();
        end
        checks++;
        if (k !== 10) begin
            failures++; $display("FAIL bp_count got=%0d want=10", k);
        end
        checks++;
        if (n !== 10) begin
            failures++; $display("FAIL bp_accepted got=%0d want=10", n);
        end
    endtask

    task automatic test_bubbles();
        logic ev;
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c < 4) drive(c % 2 == 0, c + 10, 3);
            else       drive(1'b0, 0, 0);
            #1;
            ev = (c >= 3 && c <= 6) ? ((c - 3) % 2 == 0) : 1'b0;
            checks++;
            if (bus.out_valid !== ev) begin
                failures++; $display("FAIL bubble_out_valid cycle=%0d got=%b want=%b", c, bus.out_valid, ev);
            end
            if (ev) begin
                checks++;
                if ($signed(bus.diff) !== (c - 3) + 7) begin
                    failures++; $display("FAIL bubble_diff cycle=%0d got=%0d want=%0d", c, $signed(bus.diff), (c - 3) + 7);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b1;
        drive(1'b1, 7, 1);
        tick();
        drive(1'b1, 8, 1);
        tick();
        drive(1'b0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++; $display("FAIL midrst_out_valid cycle=%0d got=%b want=0", c, bus.out_valid);
            end
            checks++;
            if (res_count !== 16'd0) begin
                failures++; $display("FAIL midrst_res_count cycle=%0d got=%0d want=0", c, res_count);
            end
            tick();
        end
    endtask

    task automatic test_counter_wrap();
        int hs = 0;
        bus_w.out_ready = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            bus_w.in_valid = (c < 17);
            bus_w.a        = WIDTH'(c);
            bus_w.d        = '0;
            #1;
            if (c == 19) begin
                checks++;
                if (res_count_w !== 4'd0) begin
                    failures++; $display("FAIL wrap_at16 got=%0d want=0", res_count_w);
                end
            end
            if (c == 20) begin
                checks++;
                if (res_count_w !== 4'd1) begin
                    failures++; $display("FAIL wrap_at17 got=%0d want=1", res_count_w);
                end
            end
            if (bus_w.out_valid && bus_w.out_ready) hs++;
            tick();
        end
        bus_w.in_valid = 1'b0;
        checks++;
        if (hs !== 17) begin
            failures++; $display("FAIL wrap_handshakes got=%0d want=17", hs);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
